// File: rtl/tetris_pkg.sv
// tetris_pkg: shared command codes and receiver FSM states (ARDUINO_PARITY_EN adds the parity state)
package tetris_pkg;
  typedef enum logic [2:0] {
    CMD_NONE      = 3'b000,
    CMD_LEFT      = 3'b001,
    CMD_RIGHT     = 3'b010,
    CMD_ROTATE    = 3'b011,
    CMD_SOFT_DROP = 3'b100,
    CMD_HARD_DROP = 3'b101,
    CMD_START     = 3'b110,
    CMD_PAUSE     = 3'b111
  } cmd_t;
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
`ifdef ARDUINO_PARITY_EN
    RX_PAR,
`endif
    RX_STOP
  } rx_state_t;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: show-ahead FIFO; a pop frees a full slot for a same-cycle push
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic do_pop, do_push;
  assign empty   = wp == rp;
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[AW-1:0]];
  // pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  // storage write; the head is read combinationally before this edge
  always_ff @(posedge clock)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/arduino_cmd_rx.sv
// arduino_cmd_rx: serial command receiver with sync, framing FSM, timeout and FIFO (ARDUINO_PARITY_EN enables parity)
module arduino_cmd_rx
  import tetris_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       arduinoClock,
  input  logic       arduinoData,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic [7:0] drop_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic clk_s1, clk_s2, clk_s3, dat_s1, dat_s2, strobe;
  rx_state_t state_q, state_d;
  logic [2:0] sh_q, sh_d, head;
  logic [1:0] bits_q, bits_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic ferr_d, push, pop, full, empty, timeout;
  assign strobe  = clk_s2 && !clk_s3;
  assign timeout = (state_q != RX_IDLE) && (cnt_q == TW'(TIMEOUT)) && !strobe;
  assign pop       = cmd_valid && cmd_ready;
  assign cmd_valid = !empty;
  assign cmd       = cmd_valid ? head : 3'd0;
`ifdef ARDUINO_PARITY_EN
  logic par_q, par_d, perr_d;
`else
  assign parity_err = 1'b0;
`endif
  // two-flop synchronizers, third clock flop for rising-edge detection
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) {clk_s1, clk_s2, clk_s3, dat_s1, dat_s2} <= '0;
    else {clk_s1, clk_s2, clk_s3, dat_s1, dat_s2} <= {arduinoClock, clk_s1, clk_s2, arduinoData, dat_s1};
  // frame FSM next state, shift register and outcome decode
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bits_d  = bits_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
`ifdef ARDUINO_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    if (timeout) begin
      state_d = RX_IDLE;
      ferr_d  = 1'b1;
    end else if (strobe)
      case (state_q)
        RX_IDLE: if (dat_s2) begin
          state_d = RX_DATA;
          bits_d  = 2'd0;
        end
        RX_DATA: begin
          sh_d   = {sh_q[1:0], dat_s2};
          bits_d = bits_q + 2'd1;
`ifdef ARDUINO_PARITY_EN
          if (bits_q == 2'd2) state_d = RX_PAR;
`else
          if (bits_q == 2'd2) state_d = RX_STOP;
`endif
        end
`ifdef ARDUINO_PARITY_EN
        RX_PAR: begin
          par_d   = dat_s2;
          state_d = RX_STOP;
        end
`endif
        RX_STOP: begin
          state_d = RX_IDLE;
          if (dat_s2) ferr_d = 1'b1;
`ifdef ARDUINO_PARITY_EN
          else if (par_q != ^sh_q) perr_d = 1'b1;
`endif
          else push = cmd_t'(sh_q) != CMD_NONE;
        end
        default: state_d = RX_IDLE;
      endcase
  end
  // timeout counter: cleared by strobes, idle while waiting for a start bit
  always_comb cnt_d = (strobe || state_q == RX_IDLE) ? '0 : (cnt_q == TW'(TIMEOUT) ? cnt_q : cnt_q + 1'b1);
  // FSM state, datapath and registered error pulses
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q   <= RX_IDLE;
      sh_q      <= '0;
      bits_q    <= '0;
      cnt_q     <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bits_q    <= bits_d;
      cnt_q     <= cnt_d;
      frame_err <= ferr_d;
    end
`ifdef ARDUINO_PARITY_EN
  // parity bit capture and parity error pulse
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      par_q      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_q      <= par_d;
      parity_err <= perr_d;
    end
`endif
  // saturating count of good frames lost to a full queue
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) drop_count <= '0;
    else if (push && full && !pop && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(3)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (sh_q),
    .dout    (head),
    .full    (full),
    .empty   (empty)
  );
endmodule

// File: tb/tb_arduino_cmd_rx.sv
// tb_arduino_cmd_rx: randomized frame stimulus against a frame-level outcome model
`timescale 1us/1ns
module tb_arduino_cmd_rx;
`ifdef ARDUINO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  logic clock = 0, reset_n = 0, arduinoClock = 0, arduinoData = 0, cmd_ready = 1;
  logic [2:0] cmd;
  logic cmd_valid, frame_err, parity_err;
  logic [7:0] drop_count;
  int checks = 0, passed = 0;
  int fe_cnt = 0, pe_cnt = 0, fe_exp = 0, pe_exp = 0, drop_exp = 0;
  logic [2:0] obs[$], exp_q[$];

  always #10 clock = ~clock;

  arduino_cmd_rx dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .arduinoClock (arduinoClock),
    .arduinoData  (arduinoData),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .drop_count   (drop_count)
  );

  always @(negedge clock)
    if (reset_n) begin
      if (frame_err) fe_cnt++;
      if (parity_err) pe_cnt++;
      if (cmd_valid && cmd_ready) obs.push_back(cmd);
    end

  task automatic chk(string tag, int got, int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  task automatic clk_wait(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(logic b);
    arduinoData = b;
    clk_wait(5);
    arduinoClock = 1;
    clk_wait(5);
    arduinoClock = 0;
  endtask

  task automatic send_frame(logic [2:0] c, logic stop, logic par_bad);
    send_bit(1'b1);
    for (int i = 2; i >= 0; i--) send_bit(c[i]);
    if (PAR_EN) send_bit((^c) ^ par_bad);
    send_bit(stop);
    clk_wait(5);
  endtask

  task automatic run_frame(string tag, logic [2:0] c, logic stop, logic par_bad);
    bit ok;
    ok = !stop && !(PAR_EN && par_bad) && c != 3'd0;
    if (stop) fe_exp++;
    else if (PAR_EN && par_bad) pe_exp++;
    obs.delete();
    send_frame(c, stop, par_bad);
    chk({tag, "_frame_err"}, fe_cnt, fe_exp);
    chk({tag, "_parity_err"}, pe_cnt, pe_exp);
    chk({tag, "_pops"}, obs.size(), ok ? 1 : 0);
    if (ok && obs.size() == 1) chk({tag, "_cmd"}, obs[0], c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    logic [2:0] c;
    clk_wait(2);
    chk("rst_cmd", cmd, 0);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_drop", drop_count, 0);
    reset_n = 1;
    clk_wait(3);
    run_frame("rotate", 3'b011, 1'b0, 1'b0);
    run_frame("bad_stop", 3'b010, 1'b1, 1'b0);
    run_frame("after_bad_stop", 3'b110, 1'b0, 1'b0);
    run_frame("bad_parity", 3'b001, 1'b0, 1'b1);
    run_frame("zero_code", 3'b000, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++)
      run_frame("rand", 3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
    chk("drop_idle", drop_count, drop_exp);
    cmd_ready = 0;
    exp_q.delete();
    for (int n = 0; n < 6; n++) begin
      c = 3'($urandom_range(1, 7));
      exp_q.push_back(c);
      send_frame(c, 1'b0, 1'b0);
    end
    drop_exp += 2;
    chk("ovf_valid", cmd_valid, 1);
    chk("ovf_head", cmd, exp_q[0]);
    chk("ovf_drop", drop_count, drop_exp);
    obs.delete();
    cmd_ready = 1;
    clk_wait(10);
    chk("drain_pops", obs.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < obs.size()) chk("drain_cmd", obs[i], exp_q[i]);
    chk("drain_valid", cmd_valid, 0);
    send_bit(1'b1);
    send_bit(1'b1);
    arduinoData = 1'b0;
    clk_wait(5);
    arduinoClock = 1;
    t = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (frame_err && t < 0) t = k;
    end
    fe_exp++;
    chk("timeout_not_early", int'(t >= 60), 1);
    chk("timeout_not_late", int'(t > 0 && t <= 72), 1);
    chk("timeout_count", fe_cnt, fe_exp);
    arduinoClock = 0;
    clk_wait(5);
    run_frame("after_timeout", 3'b100, 1'b0, 1'b0);
    cmd_ready = 0;
    send_frame(3'b110, 1'b0, 1'b0);
    chk("queued_valid", cmd_valid, 1);
    send_bit(1'b1);
    arduinoData = 1'b0;
    clk_wait(5);
    arduinoClock = 1;
    clk_wait(3);
    reset_n = 0;
    clk_wait(2);
    chk("mid_rst_cmd", cmd, 0);
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    chk("mid_rst_parity_err", parity_err, 0);
    chk("mid_rst_drop", drop_count, 0);
    arduinoClock = 0;
    cmd_ready = 1;
    reset_n = 1;
    drop_exp = 0;
    clk_wait(5);
    run_frame("after_reset", 3'b101, 1'b0, 1'b0);
    chk("final_drop", drop_count, drop_exp);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
